// File: rtl/ps2_scancode_filter.sv
// PS/2 scan-code sequencer: strips break/extended prefixes, status codes and
// typematic repeats, emitting each genuine key press as a single-cycle byte.
module ps2_scancode_filter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 1_000_000,
   parameter int TW      = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] rx_data,
   input  logic         rx_done_tick,
   output logic [N-1:0] data_out,
   output logic         data_valid,
   output logic         seq_error
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   localparam logic [N-1:0]  SC_BREAK  = N'(8'hF0);
   localparam logic [N-1:0]  SC_EXT    = N'(8'hE0);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   state_t        state_q;
   logic [N-1:0]  last_key_q;
   logic          held_q;
   logic [TW-1:0] tcnt_q;
   logic [N-1:0]  data_out_q;
   logic          data_valid_q;
   logic          seq_error_q;

   // Keyboard housekeeping bytes that never represent a key press.
   function automatic logic is_status_code(input logic [N-1:0] b);
      logic r;
      case (b)
         N'(8'h00), N'(8'hFF), N'(8'hAA), N'(8'hFA), N'(8'hFE): r = 1'b1;
         default:                                              r = 1'b0;
      endcase
      return r;
   endfunction

   // Sequence FSM, inter-byte timeout and registered output pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_key_q   <= '0;
         held_q       <= 1'b0;
         tcnt_q       <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         seq_error_q  <= 1'b0;
      end else begin
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         seq_error_q  <= 1'b0;
         if (rx_done_tick) begin
            // a received byte always wins over a timeout firing in the same cycle
            tcnt_q <= '0;
            case (state_q)
               ST_IDLE: begin
                  if (rx_data == SC_BREAK) begin
                     state_q <= ST_BRK;
                  end else if (rx_data == SC_EXT) begin
                     state_q <= ST_EXT;
                  end else if (is_status_code(rx_data)) begin
                     state_q <= ST_IDLE;
                  end else if (held_q && (rx_data == last_key_q)) begin
                     state_q <= ST_IDLE;
                  end else begin
                     data_out_q   <= rx_data;
                     data_valid_q <= 1'b1;
                     last_key_q   <= rx_data;
                     held_q       <= 1'b1;
                     state_q      <= ST_IDLE;
                  end
               end
               ST_BRK: begin
                  if (rx_data == last_key_q) begin
                     held_q <= 1'b0;
                  end else begin
                     held_q <= held_q;
                  end
                  state_q <= ST_IDLE;
               end
               ST_EXT: begin
                  if (rx_data == SC_BREAK) begin
                     state_q <= ST_EXT_BRK;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_EXT_BRK: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end else if (state_q != ST_IDLE) begin
            if (tcnt_q == TCNT_LAST) begin
               state_q     <= ST_IDLE;
               seq_error_q <= 1'b1;
               tcnt_q      <= '0;
            end else begin
               tcnt_q <= tcnt_q + TW'(1);
            end
         end else begin
            tcnt_q <= '0;
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign seq_error  = seq_error_q;

endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Randomized + directed bench for ps2_scancode_filter, checked every cycle
// against a byte-sequence model of the scan-code rules.
module tb_ps2_scancode_filter;

   localparam int N  = 8;
   localparam int TO = 16;
   localparam int TW = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] rx_data;
   logic         rx_done_tick;
   logic [N-1:0] data_out;
   logic         data_valid;
   logic         seq_error;

   ps2_scancode_filter #(.N(N), .TIMEOUT(TO), .TW(TW)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .seq_error    (seq_error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic       exp_valid = 1'b0, exp_err = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic       nxt_valid, nxt_err;
   logic [7:0] nxt_data;

   // Model: bytes of the unfinished multi-byte sequence, the held key, idle cycles.
   logic [7:0] seq[$];
   logic [7:0] m_last = 8'h00;
   bit         m_held = 1'b0;
   int         m_wait = 0;

   function automatic bit is_status(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step(input bit t, input logic [7:0] b);
      nxt_valid = 1'b0;
      nxt_data  = 8'h00;
      nxt_err   = 1'b0;
      if (t) begin
         m_wait = 0;
         if (seq.size() == 0) begin
            if (b == 8'hF0 || b == 8'hE0) seq.push_back(b);
            else if (!is_status(b) && !(m_held && b == m_last)) begin
               nxt_valid = 1'b1;
               nxt_data  = b;
               m_last    = b;
               m_held    = 1'b1;
            end
         end else if (seq[0] == 8'hF0) begin
            if (b == m_last) m_held = 1'b0;
            seq.delete();
         end else if (seq.size() == 1 && b == 8'hF0) begin
            seq.push_back(b);
         end else begin
            seq.delete();
         end
      end else if (seq.size() != 0) begin
         m_wait++;
         if (m_wait == TO) begin
            nxt_err = 1'b1;
            seq.delete();
            m_wait = 0;
         end
      end
   endtask

   // One clock: present inputs, advance model, land at posedge+1.
   task automatic cycle(input bit t, input logic [7:0] b);
      rx_done_tick = t;
      rx_data      = t ? b : 8'h00;
      model_step(t, b);
      @(posedge clk);
      #1;
      exp_valid    = nxt_valid;
      exp_data     = nxt_data;
      exp_err      = nxt_err;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
   endtask

   task automatic lit(input string nm, input bit v, input logic [7:0] d, input bit e);
      chk({nm, "_valid"}, {7'd0, data_valid}, {7'd0, v});
      chk({nm, "_data"}, data_out, d);
      chk({nm, "_err"}, {7'd0, seq_error}, {7'd0, e});
      chk({nm, "_model"}, {6'd0, exp_valid, exp_err}, {6'd0, v, e});
   endtask

   task automatic async_reset(input string nm);
      #3;
      chk_en = 1'b0;
      reset  = 1'b1;
      #1;
      chk({nm, "_valid"}, {7'd0, data_valid}, 8'h00);
      chk({nm, "_data"}, data_out, 8'h00);
      chk({nm, "_err"}, {7'd0, seq_error}, 8'h00);
      seq.delete();
      m_held = 1'b0;
      m_last = 8'h00;
      m_wait = 0;
      exp_valid = 1'b0; exp_data = 8'h00; exp_err = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   // Every-cycle comparison of DUT against model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_valid", {7'd0, data_valid}, {7'd0, exp_valid});
         chk("cyc_data", data_out, exp_data);
         chk("cyc_err", {7'd0, seq_error}, {7'd0, exp_err});
      end
   end

   logic [7:0] pool[12] = '{8'h16, 8'h1E, 8'h26, 8'h5A, 8'h33, 8'hF0,
                            8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'h75};

   initial begin
      reset        = 1'b1;
      rx_data      = 8'h00;
      rx_done_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {7'd0, data_valid}, 8'h00);
      chk("rst_data", data_out, 8'h00);
      chk("rst_err", {7'd0, seq_error}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // press, break, press again
      cycle(1'b1, 8'h5A); lit("p5a", 1'b1, 8'h5A, 1'b0);
      cycle(1'b0, 8'h00); lit("p5a_end", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'hF0); cycle(1'b1, 8'h5A); lit("b5a", 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h5A); lit("p5a_again", 1'b1, 8'h5A, 1'b0);

      // typematic
      cycle(1'b1, 8'h16); lit("t16_1", 1'b1, 8'h16, 1'b0);
      cycle(1'b1, 8'h16); lit("t16_2", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h16); lit("t16_3", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'hF0); cycle(1'b1, 8'h16); lit("t16_brk", 1'b0, 8'h00, 1'b0);

      // extended make/break then a normal key
      cycle(1'b1, 8'hE0); cycle(1'b1, 8'h75); lit("ext_make", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'hE0); cycle(1'b1, 8'hF0); cycle(1'b1, 8'h75);
      lit("ext_brk", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h1E); lit("p1e", 1'b1, 8'h1E, 1'b0);

      // timeout in BRK
      cycle(1'b1, 8'hF0);
      for (int i = 0; i < TO - 1; i++) cycle(1'b0, 8'h00);
      lit("to_pre", 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00); lit("to_fire", 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00); lit("to_end", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h26); lit("p26", 1'b1, 8'h26, 1'b0);

      // tick on the would-be timeout edge takes precedence
      cycle(1'b1, 8'hF0);
      for (int i = 0; i < TO - 1; i++) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h26); lit("to_race", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h26); lit("p26_rel", 1'b1, 8'h26, 1'b0);

      // status codes, then a key back-to-back
      cycle(1'b1, 8'hAA); cycle(1'b1, 8'hFA); cycle(1'b1, 8'h00); cycle(1'b1, 8'hFF);
      lit("status", 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h33); lit("p33", 1'b1, 8'h33, 1'b0);
      cycle(1'b1, 8'h34); lit("p34_b2b", 1'b1, 8'h34, 1'b0);

      // reset in BRK, and reset mid-pulse
      cycle(1'b1, 8'hF0);
      async_reset("rst_brk");
      cycle(1'b1, 8'h16); lit("p16_after_rst", 1'b1, 8'h16, 1'b0);
      cycle(1'b1, 8'h4D);
      async_reset("rst_pulse");
      cycle(1'b1, 8'h4D); lit("p4d_after_rst", 1'b1, 8'h4D, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) begin
            for (int j = 0; j < int'($urandom_range(TO - 2, TO + 3)); j++) cycle(1'b0, 8'h00);
         end else if ($urandom_range(0, 99) < 45) begin
            if ($urandom_range(0, 9) < 8) cycle(1'b1, pool[$urandom_range(0, 11)]);
            else cycle(1'b1, 8'($urandom_range(0, 255)));
         end else begin
            cycle(1'b0, 8'h00);
         end
      end
      cycle(1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_filter.md
# ps2_scancode_filter

Sequencing front-end between the PS/2 byte receiver and the command validation FSM. It consumes raw scan-code bytes qualified by a one-cycle receive strobe and strips break sequences, extended prefixes, keyboard status codes and typematic repeats. It presents each genuine key press to the validator as a single-cycle byte, with 8'h00 on every other cycle. This lets the validator's Enter/digit/h/n/e decoding act exactly once per physical key press.

## Interface
- N, 8, scan-code byte width
- TIMEOUT, 1_000_000, clock cycles allowed between the bytes of a multi-byte sequence (10 ms at 100 MHz)
- TW, 20, width of the timeout counter; must satisfy 2^TW > TIMEOUT

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- rx_data  in  N  byte from PS/2 receiver, valid only when rx_done_tick=1
- rx_done_tick  in  1  one-cycle strobe, byte received
- data_out  out  N  filtered make code; 8'h00 when data_valid=0
- data_valid  out  1  one-cycle pulse accompanying data_out
- seq_error  out  1  one-cycle pulse when a multi-byte sequence times out

## Operation
- All outputs are registered. Reset values: data_out=8'h00, data_valid=0, seq_error=0.
- Internal registers and their reset values:
  - state=IDLE
  - last_key=8'h00
  - held=0
  - tcnt=0
- FSM states: IDLE, BRK, EXT, EXT_BRK. Only bytes with rx_done_tick=1 are examined; rx_data is ignored otherwise.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - 00, FF, AA, FA, FE: dropped, stay IDLE.
  - Any other byte b with held=1 and b==last_key: typematic repeat, dropped, stay IDLE.
  - Any other byte b: emit (data_out=b, data_valid=1 next cycle), then last_key<=b, held<=1, stay IDLE.
- BRK: next byte b. If b==last_key, held<=0. No emit. Go to IDLE.
- EXT: next byte F0 -> EXT_BRK; any other byte is dropped (extended keys unused) -> IDLE. last_key and held are unchanged.
- EXT_BRK: next byte dropped -> IDLE; held unchanged.
- Press of a different key while one is held: the new key emits and replaces last_key. A later break of the old key does not clear held.
- Timeout:
  - tcnt clears on entry to BRK/EXT/EXT_BRK and on every rx_done_tick.
  - tcnt increments each cycle while in those states.
  - When tcnt reaches TIMEOUT-1: state<=IDLE, seq_error pulses one cycle, and last_key/held are unchanged.
  - tcnt is held at 0 in IDLE.
- data_valid and seq_error never assert in the same cycle. data_out is forced to 8'h00 whenever data_valid=0.

## Timing
- Latency: rx_done_tick at edge k with an emittable byte -> data_valid=1 and data_out=byte during cycle k+1, back to 0/8'h00 at k+2.
- Back-to-back ticks on consecutive cycles are each processed. An emit followed by another emittable byte on the next cycle produces two consecutive one-cycle pulses with no gap.
- Timeout: the state sits in BRK for exactly TIMEOUT cycles after the last tick. seq_error is high in the following cycle.
- A tick arriving in the same cycle the timeout would fire takes precedence: the byte is processed in the current state and no seq_error is generated.
- Asynchronous reset mid-sequence (any state, mid-pulse):
  - Outputs go to reset values immediately; the FSM returns to IDLE and held clears.
  - The first byte after reset release is treated as a fresh sequence start.

## Test plan
- Reset, then tick 5A -> data_valid one cycle with data_out=5A. Tick F0, then 5A -> no further pulse; held cleared. Tick 5A again -> pulse with 5A.
- Tick 16 three times (typematic), then F0 16 -> exactly one pulse, data_out=16; data_out=00 on every other cycle.
- Tick E0 75, E0 F0 75 (extended arrow) -> no pulse, state back to IDLE. Then tick 1E -> pulse with 1E.
- Tick F0 then no tick for TIMEOUT cycles (bench uses TIMEOUT=16) -> seq_error pulses once on cycle 17. Next tick 26 -> pulse with 26.
- Tick AA, FA, 00, FF -> no pulses, no seq_error. Tick 33 on the very next cycle -> pulse with 33 one cycle later.
- Tick F0, then assert reset asynchronously mid-cycle -> outputs 0 immediately. Release reset, tick 16 -> pulse with 16, not treated as a break.
